// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic [4:0]           id_rs1_addr_i;
    logic [4:0]           id_rs2_addr_i;
    logic                 id_uses_rs1_i;
    logic                 id_uses_rs2_i;
    logic [4:0]           ex_rd_addr_i;
    logic                 ex_is_load_i;
    logic                 ex_redirect_i;
    logic                 ex_mem_req_i;
    logic                 mem_ready_i;
    logic                 pc_stall_o;
    logic                 if_id_stall_o;
    logic                 if_id_flush_o;
    logic                 id_ex_stall_o;
    logic                 id_ex_flush_o;
    logic                 mem_timeout_o;
    logic [CNT_WIDTH-1:0] stall_cycles_o;

    // Datapath side: reports pipeline status, consumes sequencing controls.
    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
        output ex_rd_addr_i, ex_is_load_i, ex_redirect_i, ex_mem_req_i, mem_ready_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
        input  mem_timeout_o, stall_cycles_o
    );

    // Controller side.
    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
        input  ex_rd_addr_i, ex_is_load_i, ex_redirect_i, ex_mem_req_i, mem_ready_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
        output mem_timeout_o, stall_cycles_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer around the ID/EX register: load-use hazards,
// EX redirects and multi-cycle memory waits, plus debug counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 255,
    parameter int unsigned CNT_WIDTH        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned BUB_W  = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [WAIT_W-1:0]    wait_cnt, wait_next;
    logic [BUB_W-1:0]     bub_cnt, bub_next;
    logic                 mem_timeout, set_timeout;
    logic [CNT_WIDTH-1:0] stall_cnt;

    logic load_use, mem_block, eval_run;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c;

    // Hazard detection; x0 never produces a dependency.
    always_comb begin
        load_use  = bus.ex_is_load_i && (bus.ex_rd_addr_i != 5'd0) &&
                    ((bus.id_uses_rs1_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
                     (bus.id_uses_rs2_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));
        mem_block = bus.ex_mem_req_i && !bus.mem_ready_i;
    end

    // Next state and controls; a memory release re-evaluates redirect/load-use as in RUN.
    always_comb begin
        state_next    = state;
        wait_next     = wait_cnt;
        bub_next      = bub_cnt;
        set_timeout   = 1'b0;
        eval_run      = 1'b0;
        pc_stall_c    = 1'b0;
        if_id_stall_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_stall_c = 1'b0;
        id_ex_flush_c = 1'b0;

        case (state)
            RUN: begin
                if (mem_block) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_stall_c = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_next     = WAIT_W'(1);
                end else begin
                    eval_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ready_i && (wait_cnt < WAIT_W'(MEM_TIMEOUT))) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_stall_c = 1'b1;
                    wait_next     = wait_cnt + WAIT_W'(1);
                end else begin
                    eval_run    = 1'b1;
                    state_next  = RUN;
                    wait_next   = '0;
                    set_timeout = !bus.mem_ready_i;
                end
            end
            REDIRECT: begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                bub_next      = bub_cnt - BUB_W'(1);
                if (bub_cnt <= BUB_W'(1)) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (eval_run) begin
            if (bus.ex_redirect_i) begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                if (REDIRECT_BUBBLES > 1) begin
                    state_next = REDIRECT;
                    bub_next   = BUB_W'(REDIRECT_BUBBLES - 1);
                end
            end else if (load_use) begin
                pc_stall_c    = 1'b1;
                if_id_stall_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end
        end
    end

    // Zero-latency controls, forced low while reset is held.
    always_comb begin
        bus.pc_stall_o     = rst && pc_stall_c;
        bus.if_id_stall_o  = rst && if_id_stall_c;
        bus.if_id_flush_o  = rst && if_id_flush_c;
        bus.id_ex_stall_o  = rst && id_ex_stall_c;
        bus.id_ex_flush_o  = rst && id_ex_flush_c;
        bus.mem_timeout_o  = mem_timeout;
        bus.stall_cycles_o = stall_cnt;
    end

    // Sequencer state and wait/bubble counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            bub_cnt  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            bub_cnt  <= bub_next;
        end
    end

    // Sticky timeout flag and saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (set_timeout) begin
                mem_timeout <= 1'b1;
            end
            if (pc_stall_c && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl (2 bubbles, timeout 4, 4-bit counter).
module tb_pipeline_hazard_ctrl;
    localparam int unsigned CW = 4;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       rdr;
        logic       req;
        logic       rdy;
        logic [5:0] exp_ctl;   // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, mem_timeout}
        logic [3:0] exp_cnt;
    } vec_t;

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_LU    = 6'b110010;
    localparam logic [5:0] C_MEM   = 6'b110100;
    localparam logic [5:0] C_FLUSH = 6'b001010;
    localparam logic [5:0] C_TO    = 6'b000001;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    vec_t vecs[22];

    pipeline_hazard_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    pipeline_hazard_ctrl #(
        .REDIRECT_BUBBLES(2),
        .MEM_TIMEOUT     (4),
        .CNT_WIDTH       (CW)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic ld, logic rdr, logic req, logic rdy,
                                logic [5:0] ctl, logic [3:0] cnt);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.ld = ld;
        v.rdr = rdr; v.req = req; v.rdy = rdy; v.exp_ctl = ctl; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_rs1_addr_i = v.rs1;
        bus.id_rs2_addr_i = v.rs2;
        bus.id_uses_rs1_i = v.u1;
        bus.id_uses_rs2_i = v.u2;
        bus.ex_rd_addr_i  = v.rd;
        bus.ex_is_load_i  = v.ld;
        bus.ex_redirect_i = v.rdr;
        bus.ex_mem_req_i  = v.req;
        bus.mem_ready_i   = v.rdy;
    endtask

    function automatic logic [5:0] ctl();
        return {bus.pc_stall_o, bus.if_id_stall_o, bus.if_id_flush_o,
                bus.id_ex_stall_o, bus.id_ex_flush_o, bus.mem_timeout_o};
    endfunction

    // One cycle: drive after the edge, compare at the falling edge, advance.
    task automatic step(input string name, input vec_t v);
        drive(v);
        @(negedge clk);
        check({name, " ctl"}, 32'(ctl()), 32'(v.exp_ctl));
        check({name, " cnt"}, 32'(bus.stall_cycles_o), 32'(v.exp_cnt));
        @(posedge clk);
        #1;
    endtask

    // Reset with a live load-use hazard on the inputs; controls must stay low.
    task automatic do_reset(input string name);
        drive(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 4'd0));
        rst = 1'b0;
        #2;
        check({name, " rst ctl"}, 32'(ctl()), 32'(C_NONE));
        check({name, " rst cnt"}, 32'(bus.stall_cycles_o), 32'd0);
        drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 4'd0));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        vec_t idle, lu, memw, v;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;

        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 4'd0);
        lu   = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 4'd0);
        memw = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MEM, 4'd0);

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0);
        vecs[1]  = mk(5, 0, 1, 0, 5, 1, 0, 0, 0, C_LU,    0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  1);
        vecs[3]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, C_NONE,  1);
        vecs[4]  = mk(5, 0, 0, 0, 5, 1, 0, 0, 0, C_NONE,  1);
        vecs[5]  = mk(0, 7, 0, 1, 7, 1, 0, 0, 0, C_LU,    1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  2);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,   2);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,   3);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_MEM,   4);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE,  5);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  5);
        vecs[12] = mk(5, 0, 1, 0, 5, 1, 1, 0, 0, C_FLUSH, 5);
        vecs[13] = mk(5, 0, 1, 0, 5, 1, 0, 0, 0, C_FLUSH, 5);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  5);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_MEM,   5);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, C_FLUSH, 6);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_FLUSH, 6);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  6);
        vecs[19] = mk(5, 0, 1, 0, 5, 1, 0, 1, 0, C_MEM,   6);
        vecs[20] = mk(5, 0, 1, 0, 5, 1, 0, 1, 1, C_LU,    7);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  8);

        do_reset("init");
        for (int i = 0; i < 22; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Timeout: four stall cycles, release on the fifth, sticky flag afterwards.
        do_reset("to");
        for (int i = 0; i < 4; i++) begin
            v = memw;
            v.exp_cnt = 4'(i);
            step($sformatf("to_wait%0d", i), v);
        end
        v = memw;
        v.exp_ctl = C_NONE;
        v.exp_cnt = 4'd4;
        step("to_release", v);
        for (int i = 0; i < 3; i++) begin
            v = idle;
            v.exp_ctl = C_TO;
            v.exp_cnt = 4'd4;
            step($sformatf("to_sticky%0d", i), v);
        end
        do_reset("to_clr");
        check("to_cleared", 32'(bus.mem_timeout_o), 32'd0);

        // Async reset while frozen in a memory wait.
        v = memw;
        step("ar_enter", v);
        #2;
        rst = 1'b0;
        #1;
        check("ar_ctl", 32'(ctl()), 32'(C_NONE));
        check("ar_cnt", 32'(bus.stall_cycles_o), 32'd0);
        drive(idle);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("ar_run", idle);
        v = lu;
        step("ar_lu", v);

        // Saturation: hold a load-use hazard for 20 cycles.
        do_reset("sat");
        for (int i = 0; i < 20; i++) begin
            v = lu;
            v.exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            step($sformatf("sat%0d", i), v);
        end
        v = idle;
        v.exp_cnt = 4'd15;
        step("sat_final", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
